// File: rtl/fft_out_reorder.sv
// Reorders the 4-lane FFT output into one bin per cycle via a ping-pong buffer.
// Define FFT_REORDER_BITREV_EN for natural bin order; otherwise the raw position order is kept.
module fft_out_reorder #(
    parameter int unsigned NBITS_out = 10,
    parameter int unsigned N         = 128,
    parameter int unsigned LOG2N     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [2*NBITS_out-1:0] fftOut0_up,
    input  logic [2*NBITS_out-1:0] fftOut0_down,
    input  logic [2*NBITS_out-1:0] fftOut1_up,
    input  logic [2*NBITS_out-1:0] fftOut1_down,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*NBITS_out-1:0] out_data,
    output logic [LOG2N-1:0]       out_index,
    output logic                   out_last,
    output logic                   overflow
);

    localparam int unsigned DW = 2 * NBITS_out;
    localparam int unsigned QW = LOG2N - 2;
    localparam int unsigned AW = LOG2N + 1;
    localparam logic [QW-1:0]    QUAD_LAST = QW'(N / 4 - 1);
    localparam logic [LOG2N-1:0] BIN_LAST  = LOG2N'(N - 1);

    typedef enum logic {
        IDLE,
        FILL
    } wr_state_t;

    wr_state_t         wr_state;
    wr_state_t         wr_next;
    logic [QW-1:0]     quad_cnt;
    logic [QW-1:0]     cnt_next;
    logic [QW-1:0]     wr_k;
    logic              wr_en;
    logic              frame_done;
    logic              drop;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic              xfer;
    logic              drain;
    logic              rd_load;
    logic              rd_bank;
    logic [LOG2N-1:0]  rd_addr;
    logic [DW-1:0]     lane [4];
    logic [DW-1:0]     mem  [2*N];

    // Buffer address of stream position p.
    function automatic logic [LOG2N-1:0] wr_addr(input logic [LOG2N-1:0] p);
        logic [LOG2N-1:0] r;
`ifdef FFT_REORDER_BITREV_EN
        for (int unsigned b = 0; b < LOG2N; b++) begin
            r[b] = p[LOG2N-1-b];
        end
`else
        r = p;
`endif
        return r;
    endfunction

    always_comb begin
        lane[0] = fftOut0_up;
        lane[1] = fftOut0_down;
        lane[2] = fftOut1_up;
        lane[3] = fftOut1_down;
    end

    // Write side: IDLE waits for a start of frame, FILL counts quads.
    always_comb begin
        wr_next    = wr_state;
        cnt_next   = quad_cnt;
        wr_k       = quad_cnt;
        wr_en      = 1'b0;
        frame_done = 1'b0;
        drop       = 1'b0;
        if (in_valid && in_sof) begin
            if (full[wr_ptr]) begin
                drop     = 1'b1;
                wr_next  = IDLE;
                cnt_next = '0;
            end else begin
                wr_en = 1'b1;
                wr_k  = '0;
            end
        end else if (in_valid && (wr_state == FILL)) begin
            wr_en = 1'b1;
        end
        if (wr_en) begin
            if (wr_k == QUAD_LAST) begin
                frame_done = 1'b1;
                wr_next    = IDLE;
                cnt_next   = '0;
            end else begin
                wr_next  = FILL;
                cnt_next = wr_k + QW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // Frame buffer, intentionally without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned l = 0; l < 4; l++) begin
                mem[AW'({wr_ptr, wr_addr({wr_k, 2'(l)})})] <= lane[l];
            end
        end
    end

    // Read side: pick the next bin to present, chaining banks without a bubble.
    always_comb begin
        xfer    = out_valid && out_ready;
        drain   = xfer && out_last;
        rd_load = 1'b0;
        rd_bank = rd_ptr;
        rd_addr = out_index + LOG2N'(1);
        if (xfer && !out_last) begin
            rd_load = 1'b1;
        end else if (drain) begin
            rd_bank = ~rd_ptr;
            rd_addr = '0;
            rd_load = full[~rd_ptr];
        end else if (!out_valid && full[rd_ptr]) begin
            rd_addr = '0;
            rd_load = 1'b1;
        end
    end

    // Completion of one bank and drain of the other may coincide; both apply.
    always_comb begin
        full_next = full;
        if (frame_done) full_next[wr_ptr] = 1'b1;
        if (drain)      full_next[rd_ptr] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quad_cnt  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            full      <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            quad_cnt <= cnt_next;
            full     <= full_next;
            if (frame_done) wr_ptr <= ~wr_ptr;
            if (drain)      rd_ptr <= ~rd_ptr;
            if (drop)       overflow <= 1'b1;
            if (rd_load) begin
                out_valid <= 1'b1;
                out_data  <= mem[{rd_bank, rd_addr}];
                out_index <= rd_addr;
                out_last  <= (rd_addr == BIN_LAST);
            end else if (drain) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
